// File: rtl/neuron_tdm_scheduler_pkg.sv
// Shared definitions for the neuron TDM scheduler: FSM encoding, reset membrane value
// and index-width helper.
package snn_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_t;

  localparam int V_RESET_VAL = 0;

  function automatic int id_width(input int num_neurons);
    return (num_neurons > 1) ? $clog2(num_neurons) : 1;
  endfunction

endpackage

// File: rtl/neuron_tdm_scheduler_if.sv
// Bus bundle between the scheduler (master) and its current memory, PU and spike router.
// NEURON_SCHED_PERF_EN adds the two performance counter outputs.
interface neuron_tdm_scheduler_if #(
  parameter int ID_WIDTH   = 6,
  parameter int VMEM_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int REF_WIDTH  = 4
);
  logic                         i_step_start;
  logic                         o_busy;
  logic                         o_step_done;
  logic                         o_cur_rd;
  logic [ID_WIDTH-1:0]          o_cur_addr;
  logic signed [DATA_WIDTH-1:0] i_cur_data;
  logic                         o_pu_valid;
  logic signed [VMEM_WIDTH-1:0] o_pu_vmem;
  logic [REF_WIDTH-1:0]         o_pu_ref_ctr;
  logic signed [DATA_WIDTH-1:0] o_pu_syn_current;
  logic                         i_pu_spike;
  logic signed [VMEM_WIDTH-1:0] i_pu_vmem;
  logic [REF_WIDTH-1:0]         i_pu_ref_ctr;
  logic                         o_spike_valid;
  logic [ID_WIDTH-1:0]          o_spike_id;
  logic                         i_spike_ready;
`ifdef NEURON_SCHED_PERF_EN
  logic [31:0]                  o_spike_cnt;
  logic [31:0]                  o_stall_cnt;
`endif

  modport master (
    input  i_step_start, i_cur_data, i_pu_spike, i_pu_vmem, i_pu_ref_ctr, i_spike_ready,
    output o_busy, o_step_done, o_cur_rd, o_cur_addr, o_pu_valid, o_pu_vmem, o_pu_ref_ctr,
           o_pu_syn_current, o_spike_valid, o_spike_id
`ifdef NEURON_SCHED_PERF_EN
    , output o_spike_cnt, o_stall_cnt
`endif
  );

  modport slave (
    output i_step_start, i_cur_data, i_pu_spike, i_pu_vmem, i_pu_ref_ctr, i_spike_ready,
    input  o_busy, o_step_done, o_cur_rd, o_cur_addr, o_pu_valid, o_pu_vmem, o_pu_ref_ctr,
           o_pu_syn_current, o_spike_valid, o_spike_id
`ifdef NEURON_SCHED_PERF_EN
    , input o_spike_cnt, o_stall_cnt
`endif
  );

endinterface

// File: rtl/neuron_tdm_scheduler_fifo.sv
// First-word-fall-through spike FIFO; simultaneous push and pop (including when full)
// keep the occupancy unchanged.
module spike_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_pop;

  assign do_pop = pop && (count_reg != '0);
  assign empty  = (count_reg == '0);
  assign count  = count_reg;
  assign dout   = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)   wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/neuron_tdm_scheduler.sv
// Time-multiplexes one external neuron PU over NUM_NEURONS neurons, keeps their state and
// queues spike IDs. Defining NEURON_SCHED_PERF_EN adds spike and stall counters.
module neuron_tdm_scheduler
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS = 64,
  parameter int VMEM_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int REF_WIDTH   = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input logic                    clk,
  input logic                    rst,
  neuron_tdm_scheduler_if.master bus
);
  localparam int ID_WIDTH = id_width(NUM_NEURONS);
  localparam int CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ID_WIDTH-1:0] LAST_IDX = ID_WIDTH'(NUM_NEURONS - 1);

  sched_state_t state_reg, state_next;

  logic [ID_WIDTH-1:0]          idx_reg, s1_idx_reg, s2_idx_reg;
  logic                         s1_valid_reg, s2_valid_reg;
  logic signed [VMEM_WIDTH-1:0] vmem_mem [NUM_NEURONS];
  logic [REF_WIDTH-1:0]         ref_mem  [NUM_NEURONS];
  logic signed [VMEM_WIDTH-1:0] vmem_rd_reg;
  logic [REF_WIDTH-1:0]         ref_rd_reg;

  logic                         issue, gated, push, pop, fifo_empty;
  logic [CW-1:0]                fifo_count, in_flight;
  logic [ID_WIDTH-1:0]          fifo_dout;
  logic                         mem_we;
  logic [ID_WIDTH-1:0]          mem_waddr;
  logic signed [VMEM_WIDTH-1:0] mem_wvmem;
  logic [REF_WIDTH-1:0]         mem_wref;

  // Every neuron already in the pipeline may still spike, so reserve a FIFO slot for each.
  assign in_flight = CW'(s1_valid_reg) + CW'(s2_valid_reg);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_CLEAR;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_CLEAR: if (idx_reg == LAST_IDX) state_next = ST_IDLE;
      ST_IDLE:  if (bus.i_step_start) state_next = ST_RUN;
      ST_RUN:   if (issue && (idx_reg == LAST_IDX)) state_next = ST_DRAIN;
      // S1 empty means S2 retires its last write-back on this edge.
      ST_DRAIN: if (!s1_valid_reg) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_CLEAR;
    endcase
  end

  always_comb begin
    gated                = (CW'(FIFO_DEPTH) - fifo_count) <= in_flight;
    issue                = (state_reg == ST_RUN) && !gated;
    bus.o_busy           = (state_reg != ST_IDLE);
    bus.o_step_done      = (state_reg == ST_DONE);
    bus.o_cur_rd         = issue;
    bus.o_cur_addr       = issue ? idx_reg : '0;
    bus.o_pu_valid       = s1_valid_reg;
    bus.o_pu_vmem        = s1_valid_reg ? vmem_rd_reg : '0;
    bus.o_pu_ref_ctr     = s1_valid_reg ? ref_rd_reg : '0;
    bus.o_pu_syn_current = s1_valid_reg ? bus.i_cur_data : DATA_WIDTH'(0);
    push                 = s2_valid_reg && bus.i_pu_spike;
    pop                  = bus.i_spike_ready && !fifo_empty;
    bus.o_spike_valid    = !fifo_empty;
    bus.o_spike_id       = fifo_empty ? '0 : fifo_dout;
    mem_we               = (state_reg == ST_CLEAR) || s2_valid_reg;
    mem_waddr            = (state_reg == ST_CLEAR) ? idx_reg : s2_idx_reg;
    mem_wvmem            = (state_reg == ST_CLEAR) ? VMEM_WIDTH'(V_RESET_VAL) : bus.i_pu_vmem;
    mem_wref             = (state_reg == ST_CLEAR) ? '0 : bus.i_pu_ref_ctr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg      <= '0;
      s1_idx_reg   <= '0;
      s2_idx_reg   <= '0;
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= issue;
      s2_valid_reg <= s1_valid_reg;
      s2_idx_reg   <= s1_idx_reg;
      if (issue) s1_idx_reg <= idx_reg;
      if ((state_reg == ST_CLEAR) || issue)
        idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + ID_WIDTH'(1);
      else if ((state_reg == ST_IDLE) && bus.i_step_start)
        idx_reg <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      vmem_mem[mem_waddr] <= mem_wvmem;
      ref_mem[mem_waddr]  <= mem_wref;
    end
    if (issue) begin
      vmem_rd_reg <= vmem_mem[idx_reg];
      ref_rd_reg  <= ref_mem[idx_reg];
    end
  end

  spike_fifo #(
    .WIDTH (ID_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (s2_idx_reg),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef NEURON_SCHED_PERF_EN
  logic [31:0] spike_cnt_reg, stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      spike_cnt_reg <= '0;
      stall_cnt_reg <= '0;
    end else if ((state_reg == ST_IDLE) && bus.i_step_start) begin
      spike_cnt_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (push && !(&spike_cnt_reg)) spike_cnt_reg <= spike_cnt_reg + 32'd1;
      if ((state_reg == ST_RUN) && gated && !(&stall_cnt_reg))
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign bus.o_spike_cnt = spike_cnt_reg;
  assign bus.o_stall_cnt = stall_cnt_reg;
`endif

endmodule
